// File: rtl/edge_table_reader.sv
// Sequential edge-table walker: streams {src, dst, weight} entries over a
// valid/ready port, either all entries or only those whose src matches a query node.
module edge_table_reader #(
   parameter int N_EDGES = 8,
   parameter int W       = 8,
   parameter int CW      = $clog2(N_EDGES + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_EDGES*3*W-1:0]  edge_tbl,
   input  logic [CW-1:0]           num_edges,
   input  logic                    start,
   input  logic                    filter_en,
   input  logic [W-1:0]            query_node,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [W-1:0]            out_src,
   output logic [W-1:0]            out_dst,
   output logic [W-1:0]            out_weight,
   output logic                    busy,
   output logic                    done,
   output logic [CW-1:0]           match_count
);

   localparam int IW = (N_EDGES > 1) ? $clog2(N_EDGES) : 1;

   typedef enum logic [1:0] {IDLE, SCAN, OUT, DONE} state_t;

   state_t                       state;
   state_t                       state_nxt;
   logic [N_EDGES-1:0][2:0][W-1:0] tbl;
   logic [CW-1:0]                idx;
   logic [CW-1:0]                num_lat;
   logic [CW-1:0]                num_clamped;
   logic                         filter_lat;
   logic [W-1:0]                 query_lat;
   logic [W-1:0]                 cur_src;
   logic [W-1:0]                 cur_dst;
   logic [W-1:0]                 cur_weight;
   logic                         hit;
   logic                         last;

   // Packed view of the flat table so entry i, field k lands at [(i*3+k)*W +: W].
   assign tbl         = edge_tbl;
   assign num_clamped = (num_edges > CW'(N_EDGES)) ? CW'(N_EDGES) : num_edges;
   assign cur_src     = tbl[idx[IW-1:0]][0];
   assign cur_dst     = tbl[idx[IW-1:0]][1];
   assign cur_weight  = tbl[idx[IW-1:0]][2];
   assign hit         = !filter_lat || (cur_src == query_lat);
   assign last        = (idx == num_lat - CW'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = (num_clamped == '0) ? DONE : SCAN;
            end
         end
         SCAN: begin
            if (hit) begin
               state_nxt = OUT;
            end else if (last) begin
               state_nxt = DONE;
            end
         end
         OUT: begin
            if (out_ready) begin
               state_nxt = last ? DONE : SCAN;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      out_valid = (state == OUT);
      busy      = (state != IDLE);
      done      = (state == DONE);
   end

   // Scan parameters are captured at start so the caller may change its inputs mid-scan.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx         <= '0;
         num_lat     <= '0;
         filter_lat  <= 1'b0;
         query_lat   <= '0;
         out_src     <= '0;
         out_dst     <= '0;
         out_weight  <= '0;
         match_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  num_lat     <= num_clamped;
                  filter_lat  <= filter_en;
                  query_lat   <= query_node;
                  idx         <= '0;
                  match_count <= '0;
               end
            end
            SCAN: begin
               if (hit) begin
                  out_src    <= cur_src;
                  out_dst    <= cur_dst;
                  out_weight <= cur_weight;
               end else if (!last) begin
                  idx <= idx + CW'(1);
               end
            end
            OUT: begin
               if (out_ready) begin
                  match_count <= match_count + CW'(1);
                  if (!last) begin
                     idx <= idx + CW'(1);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_edge_table_reader.sv
// Randomized scoreboard bench for edge_table_reader: a list-based reference model
// queues expected beats and a negedge monitor pops and compares them on each handshake.
module tb_edge_table_reader;

   localparam int N  = 8;
   localparam int W  = 8;
   localparam int CW = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [N*3*W-1:0]  edge_tbl;
   logic [CW-1:0]     num_edges;
   logic              start;
   logic              filter_en;
   logic [W-1:0]      query_node;
   logic              out_valid;
   logic              out_ready;
   logic [W-1:0]      out_src;
   logic [W-1:0]      out_dst;
   logic [W-1:0]      out_weight;
   logic              busy;
   logic              done;
   logic [CW-1:0]     match_count;

   int checks = 0;
   int errors = 0;

   logic [W-1:0]      tsrc [N];
   logic [W-1:0]      tdst [N];
   logic [W-1:0]      twt  [N];
   logic [3*W-1:0]    exp_q[$];
   logic [3*W-1:0]    held;
   logic              stall_prev = 1'b0;
   logic              done_prev  = 1'b0;
   int                stall_cnt  = 0;
   int                ready_mode = 0;

   edge_table_reader #(.N_EDGES(N), .W(W), .CW(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .edge_tbl   (edge_tbl),
      .num_edges  (num_edges),
      .start      (start),
      .filter_en  (filter_en),
      .query_node (query_node),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_src    (out_src),
      .out_dst    (out_dst),
      .out_weight (out_weight),
      .busy       (busy),
      .done       (done),
      .match_count(match_count)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, expv);
      end
   endtask

   task automatic loadTable();
      for (int i = 0; i < N; i++) begin
         edge_tbl[(i*3+0)*W +: W] = tsrc[i];
         edge_tbl[(i*3+1)*W +: W] = tdst[i];
         edge_tbl[(i*3+2)*W +: W] = twt[i];
      end
   endtask

   // 0: always ready, 1: random ready, 2: hold off the first beat for 5 cycles, 3: never ready
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'($urandom_range(0, 1));
         2:       out_ready = (stall_cnt >= 5);
         default: out_ready = 1'b0;
      endcase
   end

   always @(negedge clk) begin
      if (rst) begin
         stall_prev = 1'b0;
         done_prev  = 1'b0;
      end else begin
         if (stall_prev) begin
            checkOutput("stall_hold", 32'({out_src, out_dst, out_weight}), 32'(held));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_beat actual=%0h expected=none", {out_src, out_dst, out_weight});
            end else begin
               checkOutput("beat", 32'({out_src, out_dst, out_weight}), 32'(exp_q.pop_front()));
            end
         end
         if (done) begin
            checkOutput("done_width", 32'(done_prev), 32'(0));
         end
         if (out_valid && !out_ready) begin
            stall_cnt++;
         end
         stall_prev = out_valid && !out_ready;
         held       = {out_src, out_dst, out_weight};
         done_prev  = done;
      end
   end

   task automatic applyStimulus(input int n, input logic f, input logic [W-1:0] q,
                                input int mode, input int poke_at, input bit check_lat);
      int n_eff;
      int hits;
      int misses;
      int first_hit;
      int exp_lat;
      int first_valid;
      int done_k;
      n_eff     = (n > N) ? N : n;
      hits      = 0;
      misses    = 0;
      first_hit = -1;
      for (int i = 0; i < n_eff; i++) begin
         if (!f || tsrc[i] == q) begin
            exp_q.push_back({tsrc[i], tdst[i], twt[i]});
            if (first_hit < 0) first_hit = i;
            hits++;
         end else begin
            misses++;
         end
      end
      exp_lat     = (n_eff == 0) ? 1 : 1 + misses + 2 * hits;
      first_valid = -1;
      done_k      = -1;
      ready_mode  = mode;
      stall_cnt   = 0;

      @(posedge clk); #1;
      num_edges  = CW'(n);
      filter_en  = f;
      query_node = q;
      start      = 1'b1;
      @(posedge clk); #1;
      start      = 1'b0;
      num_edges  = CW'($urandom_range(0, 15));
      filter_en  = ~f;
      query_node = ~q;

      for (int k = 1; k <= 400; k++) begin
         @(negedge clk);
         if (k == 1) checkOutput("busy_after_start", 32'(busy), 32'(1));
         if (out_valid && first_valid < 0) first_valid = k;
         start = (k == poke_at);
         if (done) begin
            done_k = k;
            break;
         end
      end

      if (done_k < 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL done_timeout actual=none expected=within400");
      end else begin
         if (check_lat) begin
            checkOutput("done_latency", 32'(done_k), 32'(exp_lat));
            if (hits > 0) checkOutput("first_valid", 32'(first_valid), 32'(first_hit + 2));
         end
         checkOutput("match_count_done", 32'(match_count), 32'(hits));
         checkOutput("leftover_beats", 32'(exp_q.size()), 32'(0));
      end
      @(negedge clk);
      start = 1'b0;
      checkOutput("busy_idle", 32'(busy), 32'(0));
      checkOutput("match_count_hold", 32'(match_count), 32'(hits));
      exp_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL global_timeout actual=running expected=finished");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int      mode;
      logic    f;
      int      fv;
      int      n;
      rst        = 1'b1;
      start      = 1'b0;
      filter_en  = 1'b0;
      query_node = '0;
      num_edges  = '0;
      out_ready  = 1'b0;
      edge_tbl   = '0;

      tsrc = '{8'd0, 8'd1, 8'd1, 8'd4, 8'd4, 8'd5, 8'd6, 8'd7};
      tdst = '{8'd0, 8'd0, 8'd2, 8'd0, 8'd2, 8'd6, 8'd6, 8'd8};
      twt  = '{8'd19, 8'd16, 8'd91, 8'd10, 8'd58, 8'd6, 8'd53, 8'd26};
      loadTable();

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_out_valid", 32'(out_valid), 32'(0));
      checkOutput("rst_busy", 32'(busy), 32'(0));
      checkOutput("rst_done", 32'(done), 32'(0));
      checkOutput("rst_out_data", 32'({out_src, out_dst, out_weight}), 32'(0));
      checkOutput("rst_match_count", 32'(match_count), 32'(0));
      rst = 1'b0;

      applyStimulus(8, 1'b1, 8'd4, 0, 3, 1'b1);
      applyStimulus(8, 1'b0, 8'd0, 0, 0, 1'b1);
      applyStimulus(8, 1'b1, 8'd1, 2, 0, 1'b0);
      applyStimulus(8, 1'b1, 8'd3, 0, 9, 1'b1);
      applyStimulus(0, 1'b0, 8'd0, 0, 0, 1'b1);
      applyStimulus(12, 1'b0, 8'd0, 0, 0, 1'b1);

      // Reset while a beat is pending: the beat is dropped and nothing is counted.
      ready_mode = 3;
      @(posedge clk); #1;
      num_edges  = 4'd8;
      filter_en  = 1'b1;
      query_node = 8'd4;
      start      = 1'b1;
      @(posedge clk); #1;
      start      = 1'b0;
      for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
      checkOutput("pending_valid", 32'(out_valid), 32'(1));
      checkOutput("pending_beat", 32'({out_src, out_dst, out_weight}), 32'({8'd4, 8'd0, 8'd10}));
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("midrst_out_valid", 32'(out_valid), 32'(0));
      checkOutput("midrst_busy", 32'(busy), 32'(0));
      checkOutput("midrst_match_count", 32'(match_count), 32'(0));
      rst = 1'b0;
      exp_q.delete();

      for (int r = 0; r < 25; r++) begin
         for (int i = 0; i < N; i++) begin
            tsrc[i] = 8'($urandom_range(0, 3));
            tdst[i] = 8'($urandom_range(0, 255));
            twt[i]  = 8'($urandom_range(0, 255));
         end
         loadTable();
         n    = $urandom_range(0, 10);
         fv   = $urandom_range(0, 1);
         f    = fv[0];
         mode = (r % 3 == 0) ? 0 : 1;
         applyStimulus(n, f, 8'($urandom_range(0, 3)), mode, 0, mode == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
